// File: rtl/freq_counter_pkg.sv
// Shared types and limits for the frequency counter front-end.
package freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam int PERIOD_W = 32;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int AVG_SHIFT_MIN   = 0;
    localparam int AVG_SHIFT_MAX   = 4;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser chain plus history flop; rise is high for one cycle per
// synchronised rising edge. rst_n is a synchronous active-high clear.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_capture.sv
// Measures clk cycles between rising edges of signal_in, averages 2^AVG_SHIFT
// consecutive periods and strobes the result; a missing edge raises timeout.
module period_capture
    import freq_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int          SYNC_STAGES    = 2,
    parameter int          AVG_SHIFT      = 2,
    parameter int unsigned TIMEOUT_CYCLES = CLOCK_FREQ
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                signal_in,
    output logic [PERIOD_W-1:0] period_time,
    output logic                measurement_done,
    output logic                timeout,
    output logic                busy
);

    localparam int                  ACC_W   = PERIOD_W + AVG_SHIFT;
    localparam int                  N_W     = AVG_SHIFT + 1;
    localparam logic [N_W-1:0]      N_LAST  = N_W'((1 << AVG_SHIFT) - 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX = PERIOD_W'(TIMEOUT_CYCLES);

    if (SYNC_STAGES < SYNC_STAGES_MIN || AVG_SHIFT < AVG_SHIFT_MIN ||
        AVG_SHIFT > AVG_SHIFT_MAX) begin : g_bad_param
        $error("period_capture: SYNC_STAGES or AVG_SHIFT out of range");
    end

    logic rise;

    edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (signal_in),
        .rise  (rise)
    );

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [N_W-1:0]      n_q, n_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                done_q, done_d;
    logic                to_q, to_d;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            period_q <= period_d;
            done_q   <= done_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        n_d      = n_q;
        period_d = period_q;
        done_d   = 1'b0;
        to_d     = 1'b0;
        acc_sum  = acc_q + ACC_W'(cnt_q);

        // Disable wins over everything, including a final rise this cycle.
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            n_d     = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = PERIOD_W'(1);
                        acc_d   = '0;
                        n_d     = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // The edge closing one period also opens the next.
                        cnt_d = PERIOD_W'(1);
                        if (n_q == N_LAST) begin
                            period_d = PERIOD_W'(acc_sum >> AVG_SHIFT);
                            done_d   = 1'b1;
                            acc_d    = '0;
                            n_d      = '0;
                        end else begin
                            acc_d = acc_sum;
                            n_d   = n_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ARM;
                        to_d    = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        n_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period_time      = period_q;
    assign measurement_done = done_q;
    assign timeout          = to_q;
    assign busy             = (state_q != IDLE);

endmodule
